// File: rtl/gsim_pkg.sv
// Shared constants and the controller state type for the Gauss-Seidel front end.
package gsim_pkg;

  localparam int unsigned N      = 16;
  localparam int unsigned IW     = 4;
  localparam int unsigned ITER   = 70;
  localparam int unsigned PE_LAT = 3;
  localparam int unsigned DW     = 32;
  localparam int unsigned BW     = 16;

  // Q16.16 fixed-point helpers
  localparam int unsigned   FRAC = 16;
  localparam logic [DW-1:0] ONE  = 32'h0001_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/gsim_xbank.sv
// Solution-vector register file: one write port, six neighbour reads around a
// base row (out-of-range neighbours read as zero) and one plain read port.
module gsim_xbank
  import gsim_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] base_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rd_m1_o,
  output logic [DW-1:0] rd_p1_o,
  output logic [DW-1:0] rd_m2_o,
  output logic [DW-1:0] rd_p2_o,
  output logic [DW-1:0] rd_m3_o,
  output logic [DW-1:0] rd_p3_o,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [N];

  // Storage: bulk clear at the start of a solve, otherwise single-word write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_m1_o = (base_i >= 4'd1)  ? mem_q[base_i - 4'd1] : '0;
  assign rd_p1_o = (base_i <= 4'd14) ? mem_q[base_i + 4'd1] : '0;
  assign rd_m2_o = (base_i >= 4'd2)  ? mem_q[base_i - 4'd2] : '0;
  assign rd_p2_o = (base_i <= 4'd13) ? mem_q[base_i + 4'd2] : '0;
  assign rd_m3_o = (base_i >= 4'd3)  ? mem_q[base_i - 4'd3] : '0;
  assign rd_p3_o = (base_i <= 4'd12) ? mem_q[base_i + 4'd3] : '0;
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gsim_feeder.sv
// Gauss-Seidel front end: loads b[], sequences rows through the PE for the
// requested number of sweeps, then streams the solution vector out.
//
//   state | meaning
//   IDLE  | waiting for the first b value
//   LOAD  | collecting b[1..15]
//   CALC  | one row per 4 cycles, PE result written back at phase 3
//   OUT   | streaming x[0..15], one word per cycle
module gsim_feeder
  import gsim_pkg::*;
#(
  parameter int unsigned N_ITER = ITER
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_en,
  input  logic [BW-1:0] b_in,
  output logic [DW-1:0] pe_in1,
  output logic [DW-1:0] pe_in2,
  output logic [DW-1:0] pe_in3,
  output logic [DW-1:0] pe_in4,
  output logic [DW-1:0] pe_in5,
  output logic [DW-1:0] pe_in6,
  output logic [BW-1:0] pe_b,
  input  logic [DW-1:0] pe_out,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] x_out,
  output logic [IW-1:0] x_idx
);

  localparam int unsigned IT_W = $clog2(N_ITER + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   row_q, row_d;
  logic [1:0]      phase_q, phase_d;
  logic [IT_W-1:0] iter_q, iter_d;
  logic [BW-1:0]   b_q [N];

  logic            b_we;
  logic [IW-1:0]   b_waddr;
  logic            x_we, x_clr;
  logic [DW-1:0]   rd_m1, rd_p1, rd_m2, rd_p2, rd_m3, rd_p3, rdata;
  logic            calc;

  gsim_xbank u_xbank (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (x_clr),
    .we_i    (x_we),
    .waddr_i (row_q),
    .wdata_i (pe_out),
    .base_i  (row_q),
    .raddr_i (cnt_q),
    .rd_m1_o (rd_m1),
    .rd_p1_o (rd_p1),
    .rd_m2_o (rd_m2),
    .rd_p2_o (rd_p2),
    .rd_m3_o (rd_m3),
    .rd_p3_o (rd_p3),
    .rdata_o (rdata)
  );

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      phase_q <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      iter_q  <= iter_d;
    end
  end

  // Right-hand-side storage, written only while loading.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) b_q[i] <= '0;
    end else if (b_we) begin
      b_q[b_waddr] <= b_in;
    end
  end

  // Next-state logic; the sweep counter runs down to zero on the last sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    phase_d = phase_q;
    iter_d  = iter_q;
    b_we    = 1'b0;
    b_waddr = cnt_q;
    x_we    = 1'b0;
    x_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_en) begin
          b_we    = 1'b1;
          b_waddr = '0;
          cnt_d   = 4'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_en) begin
          b_we  = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            x_clr   = 1'b1;
            row_d   = '0;
            phase_d = '0;
            iter_d  = IT_W'(N_ITER - 1);
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          x_we  = 1'b1;
          row_d = row_q + 4'd1;
          if (row_q == 4'd15) begin
            if (iter_q == '0) begin
              cnt_d   = '0;
              state_d = OUT;
            end else begin
              iter_d = iter_q - 1'b1;
            end
          end
        end
      end
      OUT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign calc      = (state_q == CALC);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign x_idx     = out_valid ? cnt_q : '0;
  assign x_out     = out_valid ? rdata : '0;

  // PE operands are held at zero outside CALC so the PE sees a quiet bus.
  assign pe_in1 = calc ? rd_m1 : '0;
  assign pe_in2 = calc ? rd_p1 : '0;
  assign pe_in3 = calc ? rd_m2 : '0;
  assign pe_in4 = calc ? rd_p2 : '0;
  assign pe_in5 = calc ? rd_m3 : '0;
  assign pe_in6 = calc ? rd_p3 : '0;
  assign pe_b   = calc ? b_q[row_q] : '0;

endmodule

// File: tb/tb_gsim_feeder.sv
// Directed bench for gsim_feeder with a 3-stage behavioural PE
// (x_new = ((b << 16) + sum of six neighbours) / 20) and a software
// Gauss-Seidel reference for the streamed results.
module tb_gsim_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [15:0] b_in;
  logic [31:0] pe_in1, pe_in2, pe_in3, pe_in4, pe_in5, pe_in6;
  logic [15:0] pe_b;
  logic [31:0] pe_out;
  logic        busy, out_valid;
  logic [31:0] x_out;
  logic [3:0]  x_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] bv [16];
  logic [31:0] mx [16];
  logic [31:0] p1, p2, p3;

  gsim_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .b_in      (b_in),
    .pe_in1    (pe_in1),
    .pe_in2    (pe_in2),
    .pe_in3    (pe_in3),
    .pe_in4    (pe_in4),
    .pe_in5    (pe_in5),
    .pe_in6    (pe_in6),
    .pe_b      (pe_b),
    .pe_out    (pe_out),
    .busy      (busy),
    .out_valid (out_valid),
    .x_out     (x_out),
    .x_idx     (x_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pe_f(input logic [15:0] b,
                                       input logic [31:0] a1, input logic [31:0] a2,
                                       input logic [31:0] a3, input logic [31:0] a4,
                                       input logic [31:0] a5, input logic [31:0] a6);
    longint s;
    s = (longint'($signed(b)) <<< 16) + longint'($signed(a1)) + longint'($signed(a2))
      + longint'($signed(a3)) + longint'($signed(a4)) + longint'($signed(a5))
      + longint'($signed(a6));
    return 32'(s / 20);
  endfunction

  // Behavioural PE: result appears three cycles after the operands.
  always_ff @(posedge clk) begin
    p1 <= pe_f(pe_b, pe_in1, pe_in2, pe_in3, pe_in4, pe_in5, pe_in6);
    p2 <= p1;
    p3 <= p2;
  end
  assign pe_out = p3;

  function automatic logic [31:0] xr(input int j);
    if (j < 0 || j > 15) return 32'd0;
    return mx[j];
  endfunction

  task automatic ref_run();
    for (int i = 0; i < 16; i++) mx[i] = 32'd0;
    for (int it = 0; it < 70; it++)
      for (int r = 0; r < 16; r++)
        mx[r] = pe_f(bv[r], xr(r-1), xr(r+1), xr(r-2), xr(r+2), xr(r-3), xr(r+3));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  task automatic load(input bit pause);
    @(negedge clk);
    cyc   = 0;
    in_en = 1'b1;
    b_in  = bv[0];
    for (int i = 1; i < 16; i++) begin
      if (pause && i == 8) begin
        repeat (5) begin
          step(1);
          in_en = 1'b0;
          b_in  = 16'h5A5A;
        end
      end
      step(1);
      in_en = 1'b1;
      b_in  = bv[i];
    end
    step(1);
    in_en = 1'b0;
    b_in  = 16'h0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 6000) begin
      step(1);
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL %s timeout waiting for out_valid observed=0 expected=1", tag);
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_busy_at_out"}, 32'(busy), 32'd1);
  endtask

  task automatic check_out(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), 32'(out_valid), 32'd1);
      chk($sformatf("%s_idx%0d", tag, k), 32'(x_idx), 32'(k));
      chk($sformatf("%s_x%0d", tag, k), x_out, mx[k]);
      step(1);
    end
    chk({tag, "_valid_end"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_xout"}, x_out, 32'd0);
    chk({tag, "_xidx"}, 32'(x_idx), 32'd0);
    chk({tag, "_pe1"}, pe_in1, 32'd0);
    chk({tag, "_pe2"}, pe_in2, 32'd0);
    chk({tag, "_pe3"}, pe_in3, 32'd0);
    chk({tag, "_pe4"}, pe_in4, 32'd0);
    chk({tag, "_pe5"}, pe_in5, 32'd0);
    chk({tag, "_pe6"}, pe_in6, 32'd0);
    chk({tag, "_peb"}, 32'(pe_b), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    in_en = 1'b0;
    b_in  = 16'h0;
    #1;
    check_quiet("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    step(2);
    check_quiet("idle");

    // Run A: all-zero right-hand side.
    for (int i = 0; i < 16; i++) bv[i] = 16'h0;
    ref_run();
    load(1'b0);
    chk("A_busy_calc", 32'(busy), 32'd1);
    wait_out("A", 4496);
    check_out("A");

    // Run B: b0=20 plus a few later values, load paused after b[7],
    // stray in_en pulse during CALC.
    for (int i = 0; i < 16; i++) bv[i] = 16'h0;
    bv[0]  = 16'd20;
    bv[8]  = 16'hFFD8;
    bv[12] = 16'd5;
    bv[15] = 16'd300;
    ref_run();
    load(1'b1);
    chk("B_r0_peb", 32'(pe_b), 32'd20);
    chk("B_r0_pe1", pe_in1, 32'd0);
    chk("B_r0_pe3", pe_in3, 32'd0);
    chk("B_r0_pe5", pe_in5, 32'd0);
    chk("B_r0_pe2", pe_in2, 32'd0);
    step(4);
    chk("B_r1_pe1", pe_in1, 32'h0001_0000);
    chk("B_r1_pe3", pe_in3, 32'd0);
    chk("B_r1_pe5", pe_in5, 32'd0);
    chk("B_r1_peb", 32'(pe_b), 32'd0);
    step(2);
    chk("B_r1_ph2_pe1", pe_in1, 32'h0001_0000);
    step(2);
    chk("B_r2_pe1", pe_in1, 32'h0000_0CCC);
    chk("B_r2_pe3", pe_in3, 32'h0001_0000);
    chk("B_r2_pe5", pe_in5, 32'd0);
    step(24);
    chk("B_r8_peb", 32'(pe_b), 32'h0000_FFD8);
    step(16);
    chk("B_r12_peb", 32'(pe_b), 32'd5);
    step(12);
    chk("B_r15_peb", 32'(pe_b), 32'd300);
    chk("B_r15_pe2", pe_in2, 32'd0);
    chk("B_r15_pe4", pe_in4, 32'd0);
    chk("B_r15_pe6", pe_in6, 32'd0);
    in_en = 1'b1;
    b_in  = 16'h7FFF;
    step(1);
    in_en = 1'b0;
    b_in  = 16'h0;
    step(3);
    chk("B_r0_it1_peb", 32'(pe_b), 32'd20);
    wait_out("B", 4501);
    check_out("B");

    // Run C: abort at iteration 10 row 6, then a clean reload.
    load(1'b0);
    step(10 * 64 + 6 * 4);
    chk("C_busy_before_abort", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_quiet("abort");
    @(negedge clk);
    reset = 1'b1;
    step(2);
    check_quiet("post_abort");
    load(1'b0);
    wait_out("C", 4496);
    check_out("C");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gsim_feeder.md
Name: gsim_feeder

Overview:
- Front-end controller for the Gauss-Seidel solver; sits directly upstream of the PE datapath.
- Loads the 16 right-hand-side values b[i] and holds the solution vector x[0..15] in Q16.16.
- For each unknown, drives the PE's six neighbour operands and b, writes the PE result back into x, and repeats for ITER iterations.
- Then streams the final x out.

Parameters:
- N, 16, number of unknowns; index width 4.
- ITER, 70, Gauss-Seidel sweeps before output.
- PE_LAT, 3, PE input-to-output latency in cycles.
- DW, 32, x word width (signed Q16.16).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_en  in  1  b_in valid during load.
- b_in  in  16  signed integer b value, one per accepted cycle, index 0 first.
- pe_in1..pe_in6  out  32 each  to PE: x[i-1], x[i+1], x[i-2], x[i+2], x[i-3], x[i+3].
- pe_b  out  16  to PE: b[i].
- pe_out  in  32  from PE: new x[i], Q16.16.
- busy  out  1  high from first accepted b until the last output word.
- out_valid  out  1  x_out/x_idx valid.
- x_out  out  32  final x[x_idx].
- x_idx  out  4  index of x_out.

Behaviour:
- Reset (async, low): FSM to IDLE; all x[] and b[] registers cleared.
  - busy=0, out_valid=0, x_out=0, x_idx=0.
  - pe_in*=0, pe_b=0.
- FSM states: IDLE -> LOAD -> CALC -> OUT -> IDLE.
- IDLE: in_en=1 stores b_in into b[0], sets load count=1, busy=1, goes to LOAD.
- LOAD: each in_en=1 cycle stores b_in into b[cnt] and increments cnt.
  - in_en=0 pauses the count; there is no timeout.
  - After b[15] is stored: clear all x to 0, row=0, iter=0, phase=0, go to CALC.
- CALC: 2-bit phase counter, one row per 4 cycles.
  - pe_in*/pe_b are combinational from the x/b registers for the current row and stay stable for all 4 phases.
  - Neighbour index outside 0..15 drives 0.
  - Row issued at phase 0 (cycle T). PE result is valid in cycle T+PE_LAT (phase 3).
  - On the phase-3 edge, x[row] <= pe_out. Next row issues at T+4 and sees the updated value, with no forwarding path.
  - Row wraps 15 -> 0 and increments iter. After the write of row 15 in iteration ITER-1, go to OUT.
  - One iteration = 64 cycles.
- OUT: 16 consecutive cycles with out_valid=1, x_idx=k, x_out=x[k], k=0..15.
  - On the cycle after k=15: out_valid=0, busy=0, back to IDLE.
- in_en outside IDLE/LOAD is ignored; extra b values are dropped.
- No arithmetic in this block: pe_out is stored as-is, b is passed unmodified.
- Reset in any state aborts immediately. No partial output follows.

Decomposition:
- Shared package gsim_pkg holds:
  - N, ITER, PE_LAT, DW;
  - FSM state enum {IDLE, LOAD, CALC, OUT};
  - Q16.16 constants FRAC=16, ONE=32'h0001_0000.
- One sub-module, gsim_xbank: 16x32 register file.
  - One write port.
  - Six combinational read ports at signed offsets ±1, ±2, ±3 from a 4-bit base.
  - Returns 0 for out-of-range indices.
  - Also serves the x_out read.

Test Plan:
- All b=0, ITER=70 -> busy for 16+4480+16 cycles. out_valid asserts exactly 4496 cycles after the first accepted b. All 16 x_out=0, x_idx 0..15 in order.
- ITER=1, b0=20, others 0, PE model bit-exact -> x_out[0]=32'h0001_0000 (±2 LSB) and x_out[1]≈32'h0000_0CCC (±2 LSB).
- Row-0 issue -> pe_in1/3/5=0. Row-15 issue -> pe_in2/4/6=0. Row 1 -> pe_in3=pe_in5=0 and pe_in1=x[0].
- Load with in_en dropped for 5 cycles after b[7] -> b[8..15] land at the correct indices; CALC start is delayed by 5 cycles.
- in_en pulsed during CALC with b_in=16'h7FFF -> stored b unchanged; results identical to the run without the pulse.
- reset driven low at iteration 10, row 6 -> immediate busy=0, out_valid=0, all outputs 0. A subsequent fresh load produces results identical to a clean run.
